// File: rtl/zclock_gen_pkg.sv
// Shared mode numbers and stall-FSM state encoding for the Z80 clock generator.
package zclock_gen_pkg;

  localparam int ZM_3M5 = 0;
  localparam int ZM_7M  = 1;
  localparam int ZM_14M = 2;

  typedef enum logic [1:0] {
    ZS_RUN    = 2'd0,
    ZS_STALL  = 2'd1,
    ZS_RESUME = 2'd2
  } zstate_e;

endpackage

// File: rtl/zclock_gen_if.sv
// Bundle between the Z80 clock generator and the arbiter / bus logic around it.
interface zclock_gen_if
  import zclock_gen_pkg::*;
#(
  parameter int MODE_W = 2
);

  // No valid/ready pairs here: pre_cend is a one-fclk pulse with no back-pressure,
  // stall_req is a level sampled every fclk, and zpos/zneg are one-fclk strobes.
  logic [MODE_W-1:0] turbo;
  logic              pre_cend;
  logic              stall_req;
  logic              zclk_out;
  logic              zpos;
  logic              zneg;
  logic [MODE_W-1:0] int_mode;
  logic              stalled;
  zstate_e           state;

  modport master (
    output turbo, pre_cend, stall_req,
    input  zclk_out, zpos, zneg, int_mode, stalled, state
  );

  modport slave (
    input  turbo, pre_cend, stall_req,
    output zclk_out, zpos, zneg, int_mode, stalled, state
  );

endinterface

// File: rtl/zclock_gen_sync.sv
// Divides arbiter pre_cend pulses by SYNC_DIV; sync_pt marks every SYNC_DIV-th pulse.
module zclock_gen_sync #(
  parameter int SYNC_DIV = 2
) (
  input  logic fclk,
  input  logic rst,
  input  logic pre_cend,
  output logic sync_pt
);

  localparam int SC_W = (SYNC_DIV > 1) ? $clog2(SYNC_DIV) : 1;

  logic [SC_W-1:0] sync_cnt;

  assign sync_pt = pre_cend && (sync_cnt == SC_W'(SYNC_DIV - 1));

  always_ff @(posedge fclk) begin
    if (rst) begin
      sync_cnt <= '0;
    end else if (pre_cend) begin
      sync_cnt <= sync_pt ? '0 : sync_cnt + SC_W'(1);
    end
  end

endmodule

// File: rtl/zclock_gen.sv
// Z80 clock generator: fclk / 2^(CNT_W-mode), mode changes aligned to sync points,
// with high-phase stretching in fast modes and zpos/zneg edge strobes.
module zclock_gen
  import zclock_gen_pkg::*;
#(
  parameter int CNT_W     = 3,
  parameter int MODE_W    = 2,
  parameter int SYNC_DIV  = 2,
  parameter int STALL_MIN = ZM_14M
) (
  input logic         fclk,
  input logic         rst,
  zclock_gen_if.slave zif
);

  zstate_e           state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [MODE_W-1:0] int_mode, mode_nx, turbo_cl;
  logic              zclk, zclk_nx;
  logic              cnt_bit, fall_raw, sync_pt, stalled;

  zclock_gen_sync #(.SYNC_DIV(SYNC_DIV)) u_sync (
    .fclk     (fclk),
    .rst      (rst),
    .pre_cend (zif.pre_cend),
    .sync_pt  (sync_pt)
  );

  assign turbo_cl = (int'(zif.turbo) > CNT_W - 1) ? MODE_W'(CNT_W - 1) : zif.turbo;

  // Counter bit that sets the half-period: bit CNT_W-1-int_mode.
  always_comb begin
    cnt_bit = 1'b0;
    for (int i = 0; i < CNT_W; i++) begin
      if (int'(int_mode) == CNT_W - 1 - i) cnt_bit = cnt[i];
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mode_nx  = int_mode;
    zclk_nx  = zclk;
    fall_raw = 1'b0;
    case (state)
      ZS_RUN: begin
        zclk_nx  = ~cnt_bit;
        fall_raw = zclk & cnt_bit;
        if (sync_pt) begin
          cnt_nx  = '1;
          mode_nx = turbo_cl;
        end else if (fall_raw && zif.stall_req && int'(int_mode) >= STALL_MIN) begin
          // Swallow this falling edge and freeze the phase counter.
          state_nx = ZS_STALL;
          zclk_nx  = zclk;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ZS_STALL: begin
        if (!zif.stall_req) state_nx = ZS_RESUME;
      end
      ZS_RESUME: begin
        if (sync_pt) begin
          state_nx = ZS_RUN;
          cnt_nx   = '1;
          mode_nx  = turbo_cl;
          zclk_nx  = 1'b0;
        end
      end
      default: state_nx = ZS_RUN;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state    <= ZS_RUN;
      cnt      <= '1;
      int_mode <= MODE_W'(ZM_3M5);
      zclk     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      int_mode <= mode_nx;
      zclk     <= zclk_nx;
    end
  end

  assign stalled      = (state != ZS_RUN);
  assign zif.stalled  = stalled;
  assign zif.zclk_out = zclk;
  assign zif.int_mode = int_mode;
  assign zif.state    = state;
  assign zif.zpos     = ~stalled & zclk_nx & ~zclk;
  assign zif.zneg     = ~stalled & ~zclk_nx & zclk;

endmodule

// File: tb/tb_zclock_gen.sv
// Bench for zclock_gen: directed scenarios plus random turbo/stall/reset traffic,
// checked every cycle against a phase-arithmetic reference model.
module tb_zclock_gen;
  import zclock_gen_pkg::*;

  localparam int CNT_W     = 3;
  localparam int MODE_W    = 2;
  localparam int SYNC_DIV  = 2;
  localparam int STALL_MIN = ZM_14M;

  logic fclk = 1'b0;
  logic rst  = 1'b1;

  always #5 fclk = ~fclk;

  zclock_gen_if #(.MODE_W(MODE_W)) zif();

  zclock_gen #(
    .CNT_W     (CNT_W),
    .MODE_W    (MODE_W),
    .SYNC_DIV  (SYNC_DIV),
    .STALL_MIN (STALL_MIN)
  ) dut (
    .fclk (fclk),
    .rst  (rst),
    .zif  (zif)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic chk  = 1'b0;

  logic [MODE_W-1:0] turbo_v = '0;
  logic stall_v = 1'b0;
  logic rst_v   = 1'b1;

  // Reference: clock level follows (cycles since last realign / half-period) parity.
  int m_z    = 0;
  int m_mode = 0;
  int m_pos  = 0;
  int m_st   = 0;  // 0 running, 1 held by stall_req, 2 released, waiting for sync point
  int m_pre  = 0;

  int prev_rise = -1;
  int last_rise = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    int   half, nat, nz, t_cl, n_st, n_pos, n_mode;
    logic pc, sp, e_stl;
    pc = (cyc % 8 == 7);
    rst           = rst_v;
    zif.turbo     = turbo_v;
    zif.stall_req = stall_v;
    zif.pre_cend  = pc;
    #1;
    half   = 1 << (CNT_W - 1 - m_mode);
    sp     = pc && (m_pre == SYNC_DIV - 1);
    t_cl   = (int'(turbo_v) > CNT_W - 1) ? CNT_W - 1 : int'(turbo_v);
    nz     = m_z;
    n_st   = m_st;
    n_pos  = m_pos;
    n_mode = m_mode;
    if (m_st == 0) begin
      nat = (m_pos / half) % 2;
      if (sp) begin
        nz = nat; n_pos = 0; n_mode = t_cl;
      end else if (m_z == 1 && nat == 0 && stall_v && m_mode >= STALL_MIN) begin
        n_st = 1;
      end else begin
        nz = nat; n_pos = m_pos + 1;
      end
    end else if (m_st == 1) begin
      if (!stall_v) n_st = 2;
    end else begin
      if (sp) begin
        n_st = 0; nz = 0; n_pos = 0; n_mode = t_cl;
      end
    end
    e_stl = (m_st != 0);
    if (chk) begin
      check("zclk_out", 32'(zif.zclk_out), 32'(m_z));
      check("int_mode", 32'(zif.int_mode), 32'(m_mode));
      check("stalled",  32'(zif.stalled),  32'(e_stl));
      check("zpos",     32'(zif.zpos), 32'(!e_stl && nz == 1 && m_z == 0));
      check("zneg",     32'(zif.zneg), 32'(!e_stl && nz == 0 && m_z == 1));
    end
    if (zif.zpos === 1'b1) begin
      prev_rise = last_rise;
      last_rise = cyc;
    end
    m_z = nz; m_st = n_st; m_pos = n_pos; m_mode = n_mode;
    if (pc) m_pre = (m_pre + 1) % SYNC_DIV;
    if (rst_v) begin
      m_z = 0; m_mode = 0; m_pos = 0; m_st = 0; m_pre = 0;
    end
    cyc++;
    @(posedge fclk);
    #1;
  endtask

  task automatic wait_stalled(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (zif.stalled === 1'b1) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    zif.turbo     = '0;
    zif.stall_req = 1'b0;
    zif.pre_cend  = 1'b0;
    @(posedge fclk);
    #1;
    step();
    step();
    chk   = 1'b1;
    rst_v = 1'b0;
    check("rst_zclk_out", 32'(zif.zclk_out), 32'd0);
    check("rst_int_mode", 32'(zif.int_mode), 32'(ZM_3M5));
    check("rst_stalled",  32'(zif.stalled),  32'd0);

    // 3.5 MHz: 8-cycle period
    repeat (48) step();
    check("period_m0", 32'(last_rise - prev_rise), 32'd8);

    // turbo 0->1 mid-period takes effect only at the next sync point
    step();
    turbo_v = MODE_W'(ZM_7M);
    repeat (48) step();
    check("period_m1", 32'(last_rise - prev_rise), 32'd4);
    check("mode_m1",   32'(zif.int_mode), 32'(ZM_7M));

    // 14 MHz with a 10-cycle stall
    turbo_v = MODE_W'(ZM_14M);
    repeat (20) step();
    stall_v = 1'b1;
    wait_stalled("stall_entry_m2");
    repeat (10) step();
    check("stall_hold_zclk", 32'(zif.zclk_out), 32'd1);
    check("stall_hold_flag", 32'(zif.stalled),  32'd1);
    stall_v = 1'b0;
    repeat (40) step();

    // 7 MHz ignores stall_req
    turbo_v = MODE_W'(ZM_7M);
    repeat (20) step();
    stall_v = 1'b1;
    repeat (40) step();
    check("m1_no_stall",   32'(zif.stalled), 32'd0);
    check("m1_stall_per",  32'(last_rise - prev_rise), 32'd4);
    stall_v = 1'b0;

    // turbo=3 clamps to mode 2
    turbo_v = 2'd3;
    repeat (24) step();
    check("clamp_mode",   32'(zif.int_mode), 32'd2);
    check("clamp_period", 32'(last_rise - prev_rise), 32'd2);

    // reset while stalled
    stall_v = 1'b1;
    wait_stalled("stall_entry_rst");
    repeat (3) step();
    rst_v   = 1'b1;
    stall_v = 1'b0;
    turbo_v = '0;
    step();
    rst_v = 1'b0;
    check("rst_stall_zclk",  32'(zif.zclk_out), 32'd0);
    check("rst_stall_flag",  32'(zif.stalled),  32'd0);
    check("rst_stall_mode",  32'(zif.int_mode), 32'd0);
    repeat (40) step();
    check("period_after_rst", 32'(last_rise - prev_rise), 32'd8);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) turbo_v = MODE_W'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  stall_v = ~stall_v;
      rst_v = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_v = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
